// File: rtl/sumador_serie_ctrl.sv
// sumador_serie_ctrl: bit-serial adder controller.
// Latches two WIDTH-bit operands plus carry-in, then runs one shared 1-bit full-adder slice
// LSB-first for WIDTH cycles with the carry held in a flop. Start/busy/done handshake.
// Optional build macro SUMADOR_SUB_EN adds a 'sub' input: B is captured inverted and the
// carry flop is forced to 1, giving a - b (cout=1 means no borrow).
module sumador_serie_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SUMADOR_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 bits are stored; the final bit joins them on the last RUN edge.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sum_asm;

    // Operand conditioning at capture time.
`ifdef SUMADOR_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub | cin;  // subtract forces the +1 of two's complement
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // Shared full-adder slice on the current LSBs and the carry flop.
    assign s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_next  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign sum_asm = {s_bit, sum_sh_q};

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    a_sh_d   = a;
                    b_sh_d   = b_load;
                    carry_d  = c_load;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                busy     = 1'b1;
                sum_sh_d = sum_asm[WIDTH-1:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = c_next;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    sum_d   = sum_asm;
                    cout_d  = c_next;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Self-checking bench for sumador_serie_ctrl (WIDTH=8). Expected {cout,sum} values are
// pushed to a queue when an operation is started and popped when done pulses.
// Build with SUMADOR_SUB_EN defined to also exercise the subtract option.
module tb_sumador_serie_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int          LIM   = 4 * WIDTH;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
`ifdef SUMADOR_SUB_EN
    logic             sub   = 1'b0;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int vectors     = 0;
    int miscompares = 0;
    logic [WIDTH:0] exp_q[$];

    sumador_serie_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SUMADOR_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (WIDTH + 1)'(1);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Drive a start request (call at a negedge) and record its expected result.
    task automatic drive_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic c, input logic s);
        a     = x;
        b     = y;
        cin   = c;
`ifdef SUMADOR_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        exp_q.push_back(model(x, y, c, s));
    endtask

    // Drop start after the sampling edge and wait (bounded) for done; cyc counts negedges
    // since the drive negedge, busy_cnt counts negedges with busy high before done.
    task automatic wait_done(output int cyc, output int busy_cnt);
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < LIM) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({busy, done, cout, sum} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, cout, sum} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] ta[7];
        logic [WIDTH-1:0] tb_[7];
        logic             tc[7];
        logic [WIDTH:0]   exp;
        int               cyc;
        int               bcnt;
        ta[0] = 8'h5A; tb_[0] = 8'h3C; tc[0] = 1'b0;
        ta[1] = 8'hFF; tb_[1] = 8'h01; tc[1] = 1'b0;
        ta[2] = 8'hFF; tb_[2] = 8'hFF; tc[2] = 1'b1;
        ta[3] = 8'h00; tb_[3] = 8'h00; tc[3] = 1'b1;
        for (int i = 4; i < 7; i++) begin
            ta[i]  = WIDTH'($urandom);
            tb_[i] = WIDTH'($urandom);
            tc[i]  = 1'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_op(ta[i], tb_[i], tc[i], 1'b0);
            wait_done(cyc, bcnt);
            exp = 'x;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            vectors++;
            if (cyc !== WIDTH + 1) begin
                miscompares++;
                $display("FAIL add_latency[%0d]: got %0d cycles, want %0d", i, cyc, WIDTH + 1);
            end
            vectors++;
            if (bcnt !== WIDTH || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL add_busy[%0d]: got %0d busy cycles (busy at done=%b), want %0d/0",
                         i, bcnt, busy, WIDTH);
            end
            vectors++;
            if ({cout, sum} !== exp) begin
                miscompares++;
                $display("FAIL add_result[%0d]: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || {cout, sum} !== exp) begin
                miscompares++;
                $display("FAIL add_after[%0d]: got done=%b {cout,sum}=%h, want 0 / %h",
                         i, done, {cout, sum}, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [WIDTH:0] exp;
        logic [WIDTH:0] got;
        int             pulses;
        int             cyc;
        @(negedge clk);
        drive_op(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        pulses = 0;
        got    = 'x;
        while (cyc < WIDTH + 6) begin
            if (cyc == 3) begin
                start = 1'b1;
                a     = 8'hF0;
                b     = 8'h0F;
                cin   = 1'b1;
            end
            if (cyc == 4) begin
                start = 1'b0;
                a     = 8'h33;
                b     = 8'h44;
            end
            if (done === 1'b1) begin
                pulses++;
                got = {cout, sum};
            end
            @(negedge clk);
            cyc++;
        end
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses);
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ignore_result: got {cout,sum}=%h, want %h", got, exp);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH:0] exp;
        int             pulses;
        int             cyc;
        int             bcnt;
        @(negedge clk);
        a     = 8'h80;
        b     = 8'h80;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, cout, sum} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_abort: got %0d done pulses busy=%b, want 0/0", pulses, busy);
        end
        drive_op(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done(cyc, bcnt);
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++;
        if (done !== 1'b1 || {cout, sum} !== exp) begin
            miscompares++;
            $display("FAIL midrun_repeat: got done=%b {cout,sum}=%h after %0d cycles, want 1/%h",
                     done, {cout, sum}, cyc, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] held;
        logic             stable;
        int               cyc;
        int               last;
        int               ndone;
        @(negedge clk);
        drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        cyc    = 0;
        last   = 0;
        ndone  = 0;
        held   = '0;
        stable = 1'b1;
        while (ndone < 4 && cyc < 5 * LIM) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                exp = 'x;
                if (exp_q.size() > 0) exp = exp_q.pop_front();
                vectors++;
                if ({cout, sum} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_result[%0d]: got {cout,sum}=%h, want %h",
                             ndone, {cout, sum}, exp);
                end
                vectors++;
                if (cyc - last !== ((ndone == 0) ? WIDTH + 1 : WIDTH + 2)) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", ndone,
                             cyc - last, (ndone == 0) ? WIDTH + 1 : WIDTH + 2);
                end
                if (ndone > 0) begin
                    vectors++;
                    if (stable !== 1'b1) begin
                        miscompares++;
                        $display("FAIL b2b_stable[%0d]: got sum changing between dones, want held %h",
                                 ndone, held);
                    end
                end
                last   = cyc;
                held   = sum;
                stable = 1'b1;
                ndone++;
                if (ndone < 4) drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
                else start = 1'b0;
            end else if (ndone > 0 && sum !== held) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        vectors++;
        if (ndone !== 4) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d dones, want 4", ndone);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef SUMADOR_SUB_EN
    task automatic test_sub();
        logic [WIDTH-1:0] ta[3];
        logic [WIDTH-1:0] tb_[3];
        logic             tc[3];
        logic             ts[3];
        logic [WIDTH:0]   exp;
        int               cyc;
        int               bcnt;
        ta[0] = 8'h10; tb_[0] = 8'h01; tc[0] = 1'b0; ts[0] = 1'b1;
        ta[1] = 8'h01; tb_[1] = 8'h02; tc[1] = 1'b0; ts[1] = 1'b1;
        ta[2] = 8'h01; tb_[2] = 8'h02; tc[2] = 1'b1; ts[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(ta[i], tb_[i], tc[i], ts[i]);
            wait_done(cyc, bcnt);
            exp = 'x;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            vectors++;
            if (done !== 1'b1 || {cout, sum} !== exp) begin
                miscompares++;
                $display("FAIL sub_result[%0d]: got done=%b cout=%b sum=%h, want 1/%b/%h",
                         i, done, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
            end
            @(negedge clk);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SUMADOR_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
